// File: rtl/epidemic_stats_collector.sv
// epidemic_stats_collector
//   Consumes the node-network simulator's per-tick infection vector, counts
//   the infected nodes and keeps run statistics (peak count with its tick,
//   first extinction tick). One {tick, count} record per tick is streamed
//   through a small first-word-fall-through FIFO to the host side.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   clear             start-of-run pulse; flushes stats, pipeline and FIFO
//   tick_valid        states carries a new tick's node vector this cycle
//   states            node infection states, bit i = 1 means node i infected
//   out_valid/ready   record stream handshake (FWFT)
//   out_tick/count    record payload, held stable until accepted
//   peak_count/tick   largest count since clear and the tick it first occurred
//   extinct/_tick     sticky flag and tick of the first zero-count tick
//   overflow          sticky: a record was dropped because the FIFO was full
module epidemic_stats_collector #(
    parameter int N          = 100,
    parameter int CNT_W      = 7,
    parameter int TICK_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              tick_valid,
    input  logic [N-1:0]      states,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TICK_W-1:0] out_tick,
    output logic [CNT_W-1:0]  out_count,
    output logic [CNT_W-1:0]  peak_count,
    output logic [TICK_W-1:0] peak_tick,
    output logic              extinct,
    output logic [TICK_W-1:0] extinct_tick,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    // rst and clear have identical effect on every register.
    logic flush;
    assign flush = rst | clear;

    // ---------------- Stage 0: tick numbering and vector capture ----------
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic              s0_valid;
    logic [N-1:0]      s0_states;
    logic [TICK_W-1:0] s0_tick;

    // Saturating increment: the counter sticks at all-ones.
    assign tick_next = (tick_cnt == '1) ? tick_cnt : tick_cnt + TICK_W'(1);

    always_ff @(posedge clk) begin
        if (flush) begin
            tick_cnt  <= '0;
            s0_valid  <= 1'b0;
            s0_states <= '0;
            s0_tick   <= '0;
        end else begin
            s0_valid <= tick_valid;
            if (tick_valid) begin
                tick_cnt  <= tick_next;
                s0_states <= states;
                s0_tick   <= tick_next;
            end
        end
    end

    // ---------------- Stage 1: popcount and statistics --------------------
    logic [CNT_W-1:0]  pop;
    logic              s1_valid;
    logic [CNT_W-1:0]  s1_count;
    logic [TICK_W-1:0] s1_tick;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop = pop + CNT_W'(s0_states[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid     <= 1'b0;
            s1_count     <= '0;
            s1_tick      <= '0;
            peak_count   <= '0;
            peak_tick    <= '0;
            extinct      <= 1'b0;
            extinct_tick <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_count <= pop;
                s1_tick  <= s0_tick;
                // Strict compare so ties keep the earlier tick.
                if (pop > peak_count) begin
                    peak_count <= pop;
                    peak_tick  <= s0_tick;
                end
                if (!extinct && pop == '0) begin
                    extinct      <= 1'b1;
                    extinct_tick <= s0_tick;
                end
            end
        end
    end

    // ---------------- Stage 2: record FIFO (first-word-fall-through) ------
    logic [TICK_W-1:0] mem_tick [FIFO_DEPTH];
    logic [CNT_W-1:0]  mem_count[FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              full;
    logic              pop_en;
    logic              wr_en;

    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign out_valid = (occ != '0);
    // A pop only happens on stored data, so a record written into an empty
    // FIFO cannot leave in the same cycle.
    assign pop_en    = out_valid & out_ready;
    // A full FIFO still accepts the write when a slot frees up this cycle.
    assign wr_en     = s1_valid & (~full | pop_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_tick[wr_ptr]  <= s1_tick;
            mem_count[wr_ptr] <= s1_count;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop_en})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (s1_valid && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; gating keeps the payload at zero while empty.
    assign out_tick  = out_valid ? mem_tick[rd_ptr]  : '0;
    assign out_count = out_valid ? mem_count[rd_ptr] : '0;

endmodule

// File: doc/epidemic_stats_collector.md
Name: epidemic_stats_collector

Overview:
- Sits directly downstream of the node-network simulator and consumes its N-bit per-node infection state vector once per simulation tick.
- Per tick, computes the infected-node count and tracks run statistics: peak count and its tick, extinction tick.
- Streams one record per tick through a small valid/ready FIFO to the host/logging side.
- Replaces the bench-side per-node logging with a synthesizable summary.

Parameters:
- N, 100, number of nodes (width of state vector)
- CNT_W, 7, count width; must satisfy 2^CNT_W > N
- TICK_W, 32, tick counter width
- FIFO_DEPTH, 4, output record FIFO depth (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clear  in  1  start-of-run pulse (driven together with the network's loadState); flushes stats, pipeline and FIFO
- tick_valid  in  1  states holds a new tick's node vector this cycle
- states  in  N  node infection states, bit i = 1 means node i infected
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_tick  out  TICK_W  tick number of record
- out_count  out  CNT_W  infected-node count of record
- peak_count  out  CNT_W  max count seen since clear
- peak_tick  out  TICK_W  tick at which peak_count first reached
- extinct  out  1  sticky: some tick since clear had count 0
- extinct_tick  out  TICK_W  first tick with count 0
- overflow  out  1  sticky: a record was dropped because FIFO was full

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, tick counter 0, FIFO empty, pipeline valids 0. rst has priority over everything. clear has the same effect as rst except it is a functional input.
- clear and tick_valid in the same cycle: clear wins; that tick is discarded and not counted.
- Stage 0, edge E0 with tick_valid=1:
  - Tick counter increments; the first tick after clear/reset is tick 1.
  - Counter saturates at 2^TICK_W-1 and does not wrap.
  - states is registered with its tick number.
- Stage 1, edge E1:
  - Popcount of the registered vector is registered (CNT_W bits, exact, no truncation for N < 2^CNT_W).
  - Stats update on this edge:
    - if count > peak_count: peak_count := count, peak_tick := tick.
    - Ties keep the earlier tick.
    - if !extinct and count == 0: extinct := 1, extinct_tick := tick.
    - extinct stays sticky until clear/rst.
- Stage 2, edge E2: the record {tick, count} is written to the FIFO.
  - out_valid is high in the cycle after E2 when the FIFO was previously empty. Input-to-output latency is 2 cycles.
- Throughput: tick_valid may be asserted every cycle; the pipeline never stalls the input.
- FIFO output is first-word-fall-through: out_tick/out_count are valid whenever out_valid=1 and are held stable until handshake.
  - A record pops on a cycle with out_valid & out_ready.
- Full FIFO at write:
  - Pop in the same cycle: write succeeds.
  - No pop: record dropped, overflow := 1 (sticky until clear/rst). Stats are still updated from the dropped tick.
- Empty FIFO: out_valid=0; out_ready is ignored. Simultaneous write into an empty FIFO and out_ready=1 does not pop the new record that cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter has range 0..FIFO_DEPTH.
- clear mid-operation: in-flight stage 0/1 records are discarded, FIFO emptied, out_valid=0 the next cycle, stats and tick counter zeroed.
- out_* while out_valid=0: don't-care, but must not be X after reset.

Test Plan:
- Reset then clear, single tick with states = bit0 only -> 2 cycles later out_valid=1, out_tick=1, out_count=1; peak_count=1, peak_tick=1; extinct=0.
- 5 back-to-back ticks with popcounts 1,3,3,2,0, out_ready=1 -> records (1,1),(2,3),(3,3),(4,2),(5,0) on consecutive cycles; peak_count=3, peak_tick=2; extinct=1, extinct_tick=5.
- out_ready=0, 6 ticks with FIFO_DEPTH=4 -> FIFO holds ticks 1-4, overflow=1. Then out_ready=1 drains exactly 4 records, tick 1 first.
- states all ones (N=100) -> out_count=100; a later 0 tick followed by all-ones keeps extinct_tick at the first zero tick.
- clear asserted together with tick_valid while 2 records are in flight and 3 are in the FIFO -> next cycle out_valid=0 and all stats 0; next tick is reported as tick 1.
- rst asserted mid-drain with out_valid=1 -> next cycle all outputs 0; FIFO full, simultaneous write and pop -> no overflow and record order preserved.
